// File: rtl/peridot_pfc_bank.sv
// peridot_pfc_bank -- one 8-pin I/O bank of the PERIDOT pin function controller.
//
// Holds this bank's GPIO (din/dout), pin-function and function-pin registers,
// muxes peripheral outputs onto pads and routes synchronized pads back to
// peripheral inputs. Several banks share one pfc bus; their pfc_readdata
// outputs are ORed upstream, so an unselected bank reads 0.
//
// Ports:
//   csi_clk        clock (shared with the pfc bus)
//   rsi_reset      synchronous active-high reset
//   pfc_address    [3:2] bank select, [1:0] register (0 din, 1 dout, 2 pinfunc, 3 funcpin)
//   pfc_write      single-cycle write strobe
//   pfc_writedata  write data (dout: [7:0] data, [15:8] protect mask)
//   pfc_readdata   combinational read data
//   function_out   peripheral output sources, channel 0-7
//   function_oe    peripheral output enables, channel 0-7
//   function_in    peripheral input sinks, channel 0-7
//   pin_in         raw asynchronous pad inputs
//   pin_out        registered pad output data
//   pin_oe         registered pad output enable

// Per-pin output mux: decodes one pinfunc nibble into oe/out.
module peridot_pfc_pin #(
    parameter bit IMPLEMENTED = 1'b1
) (
    input  logic [3:0] code,
    input  logic       dout_bit,
    input  logic [7:0] function_out,
    input  logic [7:0] function_oe,
    output logic       mux_oe,
    output logic       mux_out
);
    always_comb begin
        mux_oe  = 1'b0;
        mux_out = 1'b0;
        if (IMPLEMENTED) begin
            if (code == 4'h1) begin
                mux_oe  = 1'b1;
                mux_out = dout_bit;
            end else if (code[3]) begin
                mux_oe  = function_oe[code[2:0]];
                // a pad that is not driven always presents out=0
                mux_out = function_out[code[2:0]] & function_oe[code[2:0]];
            end
        end
    end
endmodule

module peridot_pfc_bank #(
    parameter int BANK_NUMBER = 0,
    parameter int PIN_WIDTH   = 8
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [3:0]  pfc_address,
    input  logic        pfc_write,
    input  logic [31:0] pfc_writedata,
    output logic [31:0] pfc_readdata,
    input  logic [7:0]  function_out,
    input  logic [7:0]  function_oe,
    output logic [7:0]  function_in,
    input  logic [7:0]  pin_in,
    output logic [7:0]  pin_out,
    output logic [7:0]  pin_oe
);
    localparam logic [15:0] PIN_MASK16 = (16'd1 << PIN_WIDTH) - 16'd1;
    localparam logic [7:0]  PIN_MASK   = PIN_MASK16[7:0];

    logic [7:0]  sync1, sync2;
    logic [7:0]  dout;
    logic [31:0] pinfunc, funcpin;
    logic [31:0] pf_mask;
    logic [7:0]  mux_oe, mux_out;
    logic [7:0]  wr_mask;
    logic        sel, wr;

    assign sel     = (pfc_address[3:2] == 2'(BANK_NUMBER));
    assign wr      = pfc_write & sel;
    assign wr_mask = pfc_writedata[15:8];

    // Unimplemented pins: pinfunc nibble reads 0, pad never driven.
    for (genvar n = 0; n < 8; n++) begin : g_pin
        assign pf_mask[4*n +: 4] = {4{PIN_MASK[n]}};

        peridot_pfc_pin #(.IMPLEMENTED(PIN_MASK[n])) u_pin (
            .code         (pinfunc[4*n +: 4]),
            .dout_bit     (dout[n]),
            .function_out (function_out),
            .function_oe  (function_oe),
            .mux_oe       (mux_oe[n]),
            .mux_out      (mux_out[n])
        );
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            sync1   <= '0;
            sync2   <= '0;
            dout    <= '0;
            pinfunc <= '0;
            funcpin <= 32'h8888_8888;
            pin_out <= '0;
            pin_oe  <= '0;
        end else begin
            sync1   <= pin_in & PIN_MASK;
            sync2   <= sync1;
            pin_out <= mux_out;
            pin_oe  <= mux_oe;
            if (wr) begin
                case (pfc_address[1:0])
                    2'd1:    dout    <= ((dout & wr_mask) | (pfc_writedata[7:0] & ~wr_mask)) & PIN_MASK;
                    2'd2:    pinfunc <= pfc_writedata & pf_mask;
                    2'd3:    funcpin <= pfc_writedata;
                    default: ;
                endcase
            end
        end
    end

    // Input routing. sync2 is already zero on unimplemented pins, so a
    // channel pointing at one of them reads 0. Channels idle high in reset.
    always_comb begin
        function_in = 8'hFF;
        if (!rsi_reset) begin
            for (int k = 0; k < 8; k++) begin
                function_in[k] = funcpin[4*k+3] ? 1'b1 : sync2[funcpin[4*k +: 3]];
            end
        end
    end

    always_comb begin
        pfc_readdata = '0;
        if (sel) begin
            case (pfc_address[1:0])
                2'd0: pfc_readdata = {24'h0, sync2};
                2'd1: pfc_readdata = {24'h0, dout};
                2'd2: pfc_readdata = pinfunc;
                2'd3: pfc_readdata = funcpin;
            endcase
        end
    end
endmodule
